// File: rtl/onehot_rr_arbiter.sv
// -----------------------------------------------------------------------------
// onehot_rr_arbiter
//
// Purpose:
//   Round-robin arbiter that hands one of N = 2**s requesters exclusive use
//   of a shared downstream port. The registered one-hot `grant` vector drives
//   the `sel` input of the one-hot mux in front of that port. A grant is
//   locked for the whole transaction and released only by the downstream
//   `resp` pulse (or by the optional watchdog).
//
// Parameters:
//   s        log2 of the requester count (N = 2**s). Must match the mux.
//   TIMEOUT  maximum cycles a grant may be held without `resp`. Only used
//            when ONEHOT_ARB_TIMEOUT_EN is defined. Legal range 1..65535.
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   req        in   N  level request, bit i = requester i
//   resp       in   1  one-cycle completion pulse from the downstream port
//   grant      out  N  registered one-hot grant, all-zero when idle
//   grant_idx  out  s  binary index of the current or last grantee
//   busy       out  1  high while a grant is held
//   timeout    out  1  one-cycle pulse on a forced (watchdog) release
//
// Configuration macro:
//   ONEHOT_ARB_TIMEOUT_EN  builds the hold-time watchdog. When undefined no
//                          counter exists, `timeout` is tied low and a grant
//                          is held until `resp`.
// -----------------------------------------------------------------------------
module onehot_rr_arbiter #(
  parameter int s       = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [(2**s)-1:0]   req,
  input  logic                resp,
  output logic [(2**s)-1:0]   grant,
  output logic [s-1:0]        grant_idx,
  output logic                busy,
  output logic                timeout
);

  localparam int N = 2**s;

  // Out-of-range TIMEOUT shows up as this named scope in the elaborated tree.
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_out_of_range
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [s-1:0]   grant_idx_q, grant_idx_d;
  logic           busy_q, busy_d;
  logic [s-1:0]   ptr_q, ptr_d;

  logic [s-1:0]   sel;
  logic [s-1:0]   cand;
  logic           expire;
  logic           release_now;

  // Rotating priority scan. Walking from the lowest priority (ptr+N-1) up to
  // the highest (ptr) and overwriting on every hit leaves the first set bit
  // at or after ptr. The s-bit add wraps modulo N because N is a power of 2.
  always_comb begin
    sel  = ptr_q;
    cand = ptr_q;
    for (int i = N - 1; i >= 0; i--) begin
      cand = ptr_q + s'(i);
      if (req[cand]) begin
        sel = cand;
      end
    end
  end

`ifdef ONEHOT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // cnt_q counts completed BUSY cycles. It sits at zero while idle, so it is
  // already clear on entry to BUSY. At cnt_q == TIMEOUT-1 the current edge
  // ends the TIMEOUT-th BUSY cycle and the grant is forced off.
  assign expire = (state_q == BUSY) && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d     = '0;
    timeout_d = 1'b0;
    if (state_q == BUSY) begin
      cnt_d = cnt_q + CNT_W'(1);
      // resp wins a tie with expiry: normal completion, no timeout pulse.
      timeout_d = expire && !resp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign release_now = resp || expire;

  // Next-state logic. grant_d is either cleared or built as a single set bit,
  // so the registered grant can never be multi-hot.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    busy_d      = busy_q;
    ptr_d       = ptr_q;
    case (state_q)
      IDLE: begin
        // resp is ignored here; only a request moves the FSM.
        if (|req) begin
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          grant_idx_d  = sel;
          busy_d       = 1'b1;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        // Requests are ignored while locked. On release the FSM always
        // passes through IDLE, so a finishing requester gets a cycle to drop
        // req before the next arbitration.
        if (release_now) begin
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = grant_idx_q + s'(1);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      busy_q      <= 1'b0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_onehot_rr_arbiter
//
// Directed test of onehot_rr_arbiter (s=2, TIMEOUT=4). A transaction-level
// model (priority pointer, owner, held-cycle count) predicts the outputs and
// is compared against the DUT on every falling edge; hand-computed literal
// expectations pin the model at key points. Timeout cases are exercised when
// ONEHOT_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_onehot_rr_arbiter;

  localparam int S  = 2;
  localparam int N  = 4;
  localparam int TO = 4;
`ifdef ONEHOT_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '0;
  logic         resp  = 1'b0;
  logic [N-1:0] grant;
  logic [S-1:0] grant_idx;
  logic         busy;
  logic         timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  onehot_rr_arbiter #(.s(S), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .resp      (resp),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int m_ptr  = 0;   // highest-priority requester
  int m_last = 0;   // current or last grantee
  int m_held = 0;   // BUSY cycles completed in the current transaction
  bit m_busy = 0;
  bit m_to   = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ptr = 0; m_last = 0; m_held = 0; m_busy = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      if (req != 0) begin
        for (int k = 0; k < N; k++) begin
          if (req[(m_ptr + k) % N]) begin
            m_last = (m_ptr + k) % N;
            break;
          end
        end
        m_busy = 1;
        m_held = 0;
      end
    end else begin
      m_to = 0;
      m_held++;
      if (resp) begin
        m_busy = 0;
        m_ptr  = (m_last + 1) % N;
      end else if (TO_EN && m_held == TO) begin
        m_busy = 0;
        m_ptr  = (m_last + 1) % N;
        m_to   = 1;
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("model_grant", 32'(grant), m_busy ? (32'd1 << m_last) : 32'd0);
    chk("model_idx", 32'(grant_idx), 32'(m_last));
    chk("model_busy", 32'(busy), 32'(m_busy));
    chk("model_timeout", 32'(timeout), 32'(m_to));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; resp = 1'b0;
    @(negedge clk);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
  endtask

  logic [N-1:0] rot_exp [5];

  initial begin
    rot_exp[0] = 4'b0001; rot_exp[1] = 4'b0010; rot_exp[2] = 4'b0100;
    rot_exp[3] = 4'b1000; rot_exp[4] = 4'b0001;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_idx", 32'(grant_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;

    // Single request
    @(negedge clk); req = 4'b0100;
    @(negedge clk);
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_idx", 32'(grant_idx), 32'd2);
    chk("single_busy", 32'(busy), 32'd1);
    req = '0; resp = 1'b1;
    @(negedge clk);
    chk("single_rel_grant", 32'(grant), 32'd0);
    chk("single_rel_busy", 32'(busy), 32'd0);
    resp = 1'b0;

    // Rotation from ptr=0 with all requesting
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rot_grant", 32'(grant), 32'(rot_exp[k]));
      resp = 1'b1;
      @(negedge clk);
      chk("rot_idle_grant", 32'(grant), 32'd0);
      resp = 1'b0;
    end
    req = '0;

    // Lock and wrap: ptr is now 1
    @(negedge clk); req = 4'b1000;
    @(negedge clk);
    chk("lock_grant", 32'(grant), 32'h8);
    req = 4'b0001;
    repeat (3) begin
      @(negedge clk);
      chk("lock_hold", 32'(grant), 32'h8);
    end
    resp = 1'b1;
    @(negedge clk);
    chk("lock_rel", 32'(grant), 32'd0);
    resp = 1'b0;
    @(negedge clk);
    chk("wrap_grant", 32'(grant), 32'h1);
    chk("wrap_idx", 32'(grant_idx), 32'd0);
    req = '0; resp = 1'b1;
    @(negedge clk); resp = 1'b0;

    // Async reset mid-transaction: ptr is now 1
    @(negedge clk); req = 4'b0010;
    @(negedge clk);
    chk("async_pre_grant", 32'(grant), 32'h2);
    req = '0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_idx", 32'(grant_idx), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk); req = 4'b1010;
    @(negedge clk);
    chk("async_post_grant", 32'(grant), 32'h2);
    req = '0; resp = 1'b1;
    @(negedge clk); resp = 1'b0;

    // Spurious resp in IDLE
    do_reset();
    resp = 1'b1;
    @(negedge clk);
    resp = 1'b0;
    chk("spur_grant", 32'(grant), 32'd0);
    chk("spur_busy", 32'(busy), 32'd0);
    chk("spur_idx", 32'(grant_idx), 32'd0);
    @(negedge clk); req = 4'b1111;
    @(negedge clk);
    chk("spur_next_grant", 32'(grant), 32'h1);
    req = '0; resp = 1'b1;
    @(negedge clk); resp = 1'b0;

`ifdef ONEHOT_ARB_TIMEOUT_EN
    // Forced release after TO BUSY cycles
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    chk("to_grant", 32'(grant), 32'h2);
    req = '0;
    repeat (3) begin
      @(negedge clk);
      chk("to_hold", 32'(grant), 32'h2);
    end
    @(negedge clk);
    chk("to_rel_grant", 32'(grant), 32'd0);
    chk("to_pulse", 32'(timeout), 32'd1);
    req = 4'b0010;
    @(negedge clk);
    chk("to_pulse_end", 32'(timeout), 32'd0);
    chk("to_regrant", 32'(grant), 32'h2);
    req = '0;
    // resp on the expiry edge wins
    repeat (3) @(negedge clk);
    resp = 1'b1;
    @(negedge clk);
    resp = 1'b0;
    chk("to_tie_grant", 32'(grant), 32'd0);
    chk("to_tie_pulse", 32'(timeout), 32'd0);
    @(negedge clk);
    chk("to_tie_after", 32'(timeout), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
